phys_reg_free_list: RTL and testbench

- Circular FIFO of free physical register tags for the rename stage.
- Feeds the phys reg map table and dispatch with a new destination tag per renamed instruction.
- Takes back freed tags (the previous mapping) from ROB commit.
- Snapshots its head pointer per branch checkpoint column and rolls back on mispredict restore, reclaiming speculatively allocated tags in one cycle.

---
 rtl/phys_reg_free_list.sv | 91 +++++++++
 tb/tb_phys_reg_free_list.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags with per-checkpoint head snapshots for rollback.
// Optional FREE_LIST_BYPASS_EN forwards an enqueued tag straight to deq_tag when the list is empty.
module phys_reg_free_list #(
  parameter int NUM_PHYS_REGS      = 64,
  parameter int NUM_ARCH_REGS      = 32,
  parameter int CHECKPOINT_COLUMNS = 4,
  parameter int FL_DEPTH           = NUM_PHYS_REGS - NUM_ARCH_REGS,
  localparam int TAG_W = $clog2(NUM_PHYS_REGS),
  localparam int IDX_W = $clog2(FL_DEPTH),
  localparam int PTR_W = IDX_W + 1,
  localparam int COL_W = $clog2(CHECKPOINT_COLUMNS)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             deq_req,
  output logic             deq_valid,
  output logic [TAG_W-1:0] deq_tag,
  input  logic             enq_valid,
  input  logic [TAG_W-1:0] enq_tag,
  input  logic             save_valid,
  input  logic [COL_W-1:0] save_column,
  input  logic             restore_valid,
  input  logic [COL_W-1:0] restore_column,
  output logic [PTR_W-1:0] free_count,
  output logic             overflow_err
);

  logic [TAG_W-1:0] entries [FL_DEPTH];
  logic [PTR_W-1:0] ckpt    [CHECKPOINT_COLUMNS];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W-1:0] head_adv, head_next, tail_next;
  logic             empty, full;
  logic             deq_fire, enq_fire, enq_drop, bypass_fire;

  always_comb begin
    empty       = (head == tail);
    full        = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
    deq_valid   = !empty;
    deq_tag     = entries[head[IDX_W-1:0]];
    bypass_fire = 1'b0;
`ifdef FREE_LIST_BYPASS_EN
    // Empty list: the freed tag is handed out directly and never touches storage if consumed.
    if (empty && enq_valid && !restore_valid) begin
      deq_valid   = 1'b1;
      deq_tag     = enq_tag;
      bypass_fire = deq_req;
    end
`endif
    deq_fire  = deq_req && !empty && !restore_valid;
    enq_fire  = enq_valid && !bypass_fire && (!full || deq_fire);
    enq_drop  = enq_valid && full && !deq_fire;
    head_adv  = head + PTR_W'(deq_fire);
    head_next = restore_valid ? ckpt[restore_column] : head_adv;
    tail_next = tail + PTR_W'(enq_fire);
  end

  assign free_count = tail - head;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head <= '0;
      tail <= PTR_W'(FL_DEPTH);
    end else begin
      head <= head_next;
      tail <= tail_next;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < FL_DEPTH; i++) entries[i] <= TAG_W'(NUM_ARCH_REGS + i);
    end else if (enq_fire) begin
      entries[tail[IDX_W-1:0]] <= enq_tag;
    end
  end

  // Snapshot is head after this cycle's dequeue, so the branch's own tag stays allocated.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int c = 0; c < CHECKPOINT_COLUMNS; c++) ckpt[c] <= '0;
    end else if (save_valid && !restore_valid) begin
      ckpt[save_column] <= head_adv;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)         overflow_err <= 1'b0;
    else if (enq_drop) overflow_err <= 1'b1;
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed and randomized checks of phys_reg_free_list against a queue-based free-list model.
module tb_phys_reg_free_list;
  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       deq_req = 1'b0, deq_valid;
  logic [5:0] deq_tag;
  logic       enq_valid = 1'b0;
  logic [5:0] enq_tag = '0;
  logic       save_valid = 1'b0;
  logic [1:0] save_column = '0;
  logic       restore_valid = 1'b0;
  logic [1:0] restore_column = '0;
  logic [5:0] free_count;
  logic       overflow_err;

  phys_reg_free_list dut (
    .CLK(CLK), .nRST(nRST),
    .deq_req(deq_req), .deq_valid(deq_valid), .deq_tag(deq_tag),
    .enq_valid(enq_valid), .enq_tag(enq_tag),
    .save_valid(save_valid), .save_column(save_column),
    .restore_valid(restore_valid), .restore_column(restore_column),
    .free_count(free_count), .overflow_err(overflow_err)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Model: free tags in hand-out order, plus the history of every tag handed out.
  // A checkpoint is the number of hand-outs at save time; restore gives back later hand-outs.
  int fl[$];
  int hist[$];
  int ckpt_m[4];
  int npop;
  bit err_m;

  logic       obs_valid, obs_err;
  logic [5:0] obs_tag, obs_fc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fl.delete();
    hist.delete();
    for (int i = 0; i < 32; i++) fl.push_back(32 + i);
    for (int c = 0; c < 4; c++) ckpt_m[c] = 0;
    npop = 0;
    err_m = 1'b0;
  endtask

  function automatic bit can_restore(input int c, input int enq);
    return (ckpt_m[c] <= npop) && ((npop - ckpt_m[c]) + fl.size() + enq <= 32);
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    #2;
    nRST = 1'b0;
    deq_req = 0; enq_valid = 0; save_valid = 0; restore_valid = 0;
    #1;
    chk("rst_deq_valid", deq_valid, 1);
    chk("rst_deq_tag", deq_tag, 32);
    chk("rst_free_count", free_count, 32);
    chk("rst_overflow", overflow_err, 0);
    model_reset();
    @(negedge CLK);
    #2 nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic step(input bit dq, input bit eq, input int et, input bit sv, input int sc,
                      input bit rs, input int rc);
    bit ev, byp, deff;
    int etg, sz, k;
    deq_req = dq; enq_valid = eq; enq_tag = 6'(et);
    save_valid = sv; save_column = 2'(sc);
    restore_valid = rs; restore_column = 2'(rc);
    #1;
    sz  = fl.size();
    ev  = (sz > 0);
    etg = (sz > 0) ? fl[0] : 0;
    byp = 1'b0;
`ifdef FREE_LIST_BYPASS_EN
    if (sz == 0 && eq && !rs) begin ev = 1'b1; etg = et; byp = dq; end
`endif
    obs_valid = deq_valid; obs_tag = deq_tag; obs_fc = free_count; obs_err = overflow_err;
    chk("deq_valid", deq_valid, ev);
    if (ev) chk("deq_tag", deq_tag, etg);
    chk("free_count", free_count, sz);
    chk("overflow_err", overflow_err, err_m);
    @(posedge CLK);
    deff = dq && (sz > 0) && !rs;
    if (deff) begin hist.push_back(fl.pop_front()); npop++; end
    if (eq && !byp) begin
      if (sz == 32 && !deff) err_m = 1'b1;
      else fl.push_back(et);
    end
    if (sv && !rs) ckpt_m[sc] = npop;
    if (rs) begin
      k = ckpt_m[rc];
      for (int j = npop - 1; j >= k; j--) fl.push_front(hist[j]);
      while (hist.size() > k) void'(hist.pop_back());
      npop = k;
    end
    @(negedge CLK);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and full drain in order
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      chk("drain_tag", obs_tag, 32 + i);
    end
    idle();
    chk("drained_valid", obs_valid, 0);
    chk("drained_count", obs_fc, 0);

    // From empty: enq 7, 9 then deq twice
    step(0, 1, 7, 0, 0, 0, 0);  chk("fc0", obs_fc, 0);
    step(0, 1, 9, 0, 0, 0, 0);  chk("fc1", obs_fc, 1);
    step(1, 0, 0, 0, 0, 0, 0);  chk("fc2", obs_fc, 2); chk("tag7", obs_tag, 7);
    step(1, 0, 0, 0, 0, 0, 0);  chk("fc1b", obs_fc, 1); chk("tag9", obs_tag, 9);
    idle();                     chk("fc0b", obs_fc, 0);

    // Empty list, enqueue 12 with deq_req in the same cycle
    step(1, 1, 12, 0, 0, 0, 0);
`ifdef FREE_LIST_BYPASS_EN
    chk("byp_valid", obs_valid, 1);
    chk("byp_tag", obs_tag, 12);
    idle();
    chk("byp_fc", obs_fc, 0);
    chk("byp_after_valid", obs_valid, 0);
`else
    chk("nobyp_valid", obs_valid, 0);
    idle();
    chk("nobyp_next_valid", obs_valid, 1);
    chk("nobyp_next_tag", obs_tag, 12);
    chk("nobyp_fc", obs_fc, 1);
`endif

    // Overflow: enqueue into a full list without a dequeue
    do_reset();
    step(0, 1, 5, 0, 0, 0, 0);
    idle();
    chk("ovf_set", obs_err, 1);
    chk("ovf_fc", obs_fc, 32);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0, 0, 0);
    idle();
    chk("ovf_sticky", obs_err, 1);

    // Full list, enqueue with a dequeue is accepted
    do_reset();
    step(1, 1, 5, 0, 0, 0, 0);
    idle();
    chk("full_deq_err", obs_err, 0);
    chk("full_deq_fc", obs_fc, 32);
    for (int i = 0; i < 32; i++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      if (i == 31) chk("full_deq_last", obs_tag, 5);
    end

    // Checkpoint save and restore
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 2, 0, 0);  chk("ck_tag34", obs_tag, 34);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);  chk("ck_tag36", obs_tag, 36);
    step(1, 0, 0, 0, 0, 1, 2);
    idle();
    chk("ck_restored_tag", obs_tag, 35);
    chk("ck_restored_fc", obs_fc, 29);

    // Sustained enqueue+dequeue across pointer wrap
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(1, 1, $urandom_range(0, 63), 0, 0, 0, 0);
      chk("wrap_fc", obs_fc, 31);
    end

    // Randomized traffic with saves, valid restores and a mid-run reset
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit dq, eq, sv, rs;
      int sc, rc;
      if (n == 300) do_reset();
      dq = ($urandom_range(0, 99) < 55);
      eq = ($urandom_range(0, 99) < 45);
      sv = ($urandom_range(0, 99) < 20);
      sc = $urandom_range(0, 3);
      rc = $urandom_range(0, 3);
      rs = ($urandom_range(0, 99) < 10) && can_restore(rc, int'(eq));
      step(dq, eq, $urandom_range(0, 63), sv, sc, rs, rc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
